// File: rtl/game_master_fsm_multi.sv
// game_master_fsm_multi: round/game sequencer for the sprite shooter, driving sprite strobes and score/lives bookkeeping.
module game_master_fsm_multi #(
  parameter int N_TARGETS = 3,
  parameter int MAX_LIVES = 3,
  parameter int WIN_SCORE = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 launch_key,
  input  logic                 collision,
  input  logic                 collision_bullet,
  input  logic [N_TARGETS-1:0] target_within_screen,
  input  logic                 spaceship_within_screen,
  input  logic                 bullet_within_screen,
  input  logic                 end_of_game_timer_running,
  output logic [N_TARGETS-1:0] target_write_xy,
  output logic [N_TARGETS-1:0] target_write_dxy,
  output logic [N_TARGETS-1:0] target_enable_update,
  output logic                 spaceship_write_xy,
  output logic                 spaceship_write_dxy,
  output logic                 spaceship_enable_update,
  output logic                 bullet_write_xy,
  output logic                 bullet_write_dxy,
  output logic                 bullet_enable_update,
  output logic [MAX_LIVES-1:0] heart_visible,
  output logic                 end_of_game_timer_start,
  output logic                 game_won,
  output logic                 game_over,
  output logic [2:0]           score,
  output logic [2:0]           n_lives,
  output logic [2:0]           state_dbg
);
  typedef enum logic [2:0] {
    START_GAME  = 3'd0,
    START_ROUND = 3'd1,
    AIM         = 3'd2,
    SHOOT       = 3'd3,
    END_ROUND   = 3'd4,
    END_GAME    = 3'd5
  } state_t;
  state_t state_q, state_d;
  logic [2:0] score_q, score_d, lives_q, lives_d, cnt_q, cnt_d;
  logic won_q, won_d, seen_q, seen_d, first_q;
  logic tgt_xy_q, tgt_en_q, ship_dxy_q, ship_en_q, bul_dxy_q, timer_start_q;
  logic round_end;
  logic [2:0] lives_dec, score_inc;
  assign round_end = ~&target_within_screen | ~spaceship_within_screen | ~bullet_within_screen;
  assign lives_dec = (lives_q == 3'd0) ? lives_q : lives_q - 3'd1;
  assign score_inc = (score_q == 3'(WIN_SCORE)) ? score_q : score_q + 3'd1;
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    won_d   = won_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    case (state_q)
      START_GAME: begin
        score_d = 3'd0;
        lives_d = 3'(MAX_LIVES);
        won_d   = 1'b0;
        state_d = START_ROUND;
      end
      START_ROUND: state_d = AIM;
      AIM: begin
        if (collision) begin
          lives_d = lives_dec;
          state_d = END_ROUND;
        end else if (collision_bullet) state_d = END_ROUND;
        else if (launch_key) state_d = SHOOT;
        else if (round_end) state_d = END_ROUND;
      end
      SHOOT: begin
        if (collision) begin
          lives_d = lives_dec;
          state_d = END_ROUND;
        end else if (collision_bullet) begin
          score_d = score_inc;
          state_d = END_ROUND;
        end else if (round_end) state_d = END_ROUND;
      end
      END_ROUND: begin
        seen_d = 1'b0;
        cnt_d  = 3'd0;
        if (score_q == 3'(WIN_SCORE)) begin
          won_d   = 1'b1;
          state_d = END_GAME;
        end else if (lives_q == 3'd0) begin
          won_d   = 1'b0;
          state_d = END_GAME;
        end else state_d = START_ROUND;
      end
      END_GAME: begin
        // cnt_q saturates so the entry cycle (cnt_q==0) is never revisited
        cnt_d  = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        seen_d = seen_q | end_of_game_timer_running;
        if (!end_of_game_timer_running && (seen_q || cnt_q >= 3'd5)) state_d = START_GAME;
      end
      default: state_d = START_GAME;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= START_GAME;
      score_q       <= 3'd0;
      lives_q       <= 3'(MAX_LIVES);
      won_q         <= 1'b0;
      seen_q        <= 1'b0;
      cnt_q         <= 3'd0;
      first_q       <= 1'b0;
      tgt_xy_q      <= 1'b0;
      tgt_en_q      <= 1'b0;
      ship_dxy_q    <= 1'b0;
      ship_en_q     <= 1'b0;
      bul_dxy_q     <= 1'b0;
      timer_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      won_q         <= won_d;
      seen_q        <= seen_d;
      cnt_q         <= cnt_d;
      first_q       <= (state_d == SHOOT) && (state_q != SHOOT);
      tgt_xy_q      <= state_q == START_ROUND;
      tgt_en_q      <= (state_q == AIM) || (state_q == SHOOT);
      ship_dxy_q    <= (state_q == SHOOT) && first_q;
      ship_en_q     <= state_q == SHOOT;
      bul_dxy_q     <= (state_q == SHOOT) && first_q;
      timer_start_q <= (state_q == END_GAME) && (cnt_q == 3'd0);
    end
  end
  assign target_write_xy         = {N_TARGETS{tgt_xy_q}};
  assign target_write_dxy        = {N_TARGETS{tgt_xy_q}};
  assign target_enable_update    = {N_TARGETS{tgt_en_q}};
  assign spaceship_write_xy      = tgt_xy_q;
  assign spaceship_write_dxy     = ship_dxy_q;
  assign spaceship_enable_update = ship_en_q;
  assign bullet_write_xy         = tgt_xy_q;
  assign bullet_write_dxy        = bul_dxy_q;
  assign bullet_enable_update    = ship_en_q;
  assign end_of_game_timer_start = timer_start_q;
  assign game_won                = won_q;
  assign game_over               = state_q == END_GAME;
  assign score                   = score_q;
  assign n_lives                 = lives_q;
  assign state_dbg               = state_q;
  for (genvar h = 0; h < MAX_LIVES; h++) begin : g_heart
    assign heart_visible[h] = lives_q > 3'(h);
  end
endmodule

// File: tb/tb_game_master_fsm_multi.sv
// tb_game_master_fsm_multi: directed and random rounds checked against a score/lives game model.
module tb_game_master_fsm_multi;
  localparam int NT = 3, ML = 3, WS = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic launch_key = 1'b0, collision = 1'b0, collision_bullet = 1'b0;
  logic [NT-1:0] target_within_screen = '1;
  logic spaceship_within_screen = 1'b1, bullet_within_screen = 1'b1;
  logic end_of_game_timer_running = 1'b0;
  logic [NT-1:0] target_write_xy, target_write_dxy, target_enable_update;
  logic spaceship_write_xy, spaceship_write_dxy, spaceship_enable_update;
  logic bullet_write_xy, bullet_write_dxy, bullet_enable_update;
  logic [ML-1:0] heart_visible;
  logic end_of_game_timer_start, game_won, game_over;
  logic [2:0] score, n_lives, state_dbg;
  int passes = 0, fails = 0, total = 0;
  int exp_score = 0, exp_lives = ML;
  game_master_fsm_multi #(.N_TARGETS(NT), .MAX_LIVES(ML), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst(rst), .launch_key(launch_key), .collision(collision),
    .collision_bullet(collision_bullet), .target_within_screen(target_within_screen),
    .spaceship_within_screen(spaceship_within_screen), .bullet_within_screen(bullet_within_screen),
    .end_of_game_timer_running(end_of_game_timer_running),
    .target_write_xy(target_write_xy), .target_write_dxy(target_write_dxy),
    .target_enable_update(target_enable_update), .spaceship_write_xy(spaceship_write_xy),
    .spaceship_write_dxy(spaceship_write_dxy), .spaceship_enable_update(spaceship_enable_update),
    .bullet_write_xy(bullet_write_xy), .bullet_write_dxy(bullet_write_dxy),
    .bullet_enable_update(bullet_enable_update), .heart_visible(heart_visible),
    .end_of_game_timer_start(end_of_game_timer_start), .game_won(game_won),
    .game_over(game_over), .score(score), .n_lives(n_lives), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] hearts(input int l);
    return (32'd1 << l) - 32'd1;
  endfunction
  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_dbg !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, state_dbg, s);
  endtask
  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, state_dbg, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, n_lives, ML);
    chk({tag, "_heart"}, heart_visible, hearts(ML));
    chk({tag, "_strobes"}, {target_write_xy, target_enable_update, spaceship_write_dxy,
        bullet_write_dxy, bullet_enable_update, end_of_game_timer_start}, 0);
    chk({tag, "_won_over"}, {game_won, game_over}, 0);
  endtask
  task automatic start_round();
    int n = 0, pulses = 0;
    while (state_dbg !== 3'd2 && n < 10) begin
      @(negedge clk);
      n++;
      if (target_write_xy === '1 && bullet_write_xy && spaceship_write_xy) pulses++;
    end
    chk("reach_aim", state_dbg, 2);
    chk("write_xy_pulses", pulses, 1);
    chk("aim_score", score, exp_score);
    chk("aim_lives", n_lives, exp_lives);
    chk("aim_heart", heart_visible, hearts(exp_lives));
  endtask
  task automatic end_game();
    bit use_timer;
    chk("game_over", game_over, 1);
    chk("game_won", game_won, exp_score == WS);
    @(negedge clk);
    chk("timer_start", end_of_game_timer_start, 1);
    use_timer = $urandom_range(0, 3) != 0;
    if (use_timer) begin
      end_of_game_timer_running = 1'b1;
      repeat (10) @(negedge clk);
      chk("hold_in_end_game", {state_dbg, game_over, game_won}, {3'd5, 1'b1, exp_score == WS});
      end_of_game_timer_running = 1'b0;
      wait_state(0, 4, "timer_exit");
    end else begin
      @(negedge clk);
      chk("no_early_timeout", state_dbg, 5);
      wait_state(0, 10, "timeout_exit");
    end
    @(negedge clk);
    chk("new_game", {state_dbg, score, n_lives, game_won, game_over}, {3'd1, 3'd0, 3'(ML), 1'b0, 1'b0});
    exp_score = 0;
    exp_lives = ML;
  endtask
  // kind: 0 crash in AIM, 1 bullet hit in AIM, 2 shot hit, 3 shot with crash+hit, 4 shot off-screen, 5 off-screen in AIM
  task automatic play_round(input int kind);
    int pulses = 0;
    bit shoot;
    start_round();
    shoot = kind inside {2, 3, 4};
    if (shoot) begin
      launch_key = 1'b1;
      @(negedge clk);
      launch_key = 1'b0;
      chk("in_shoot", state_dbg, 3);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (bullet_write_dxy && spaceship_write_dxy) pulses++;
        chk("shoot_hold", state_dbg, 3);
      end
    end
    case (kind)
      0: begin collision = 1'b1; exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0; end
      1: collision_bullet = 1'b1;
      2: begin collision_bullet = 1'b1; exp_score = (exp_score < WS) ? exp_score + 1 : WS; end
      3: begin collision = 1'b1; collision_bullet = 1'b1; exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0; end
      4: if ($urandom_range(0, 1) != 0) bullet_within_screen = 1'b0; else spaceship_within_screen = 1'b0;
      default: target_within_screen = NT'($urandom_range(0, (1 << NT) - 2));
    endcase
    @(negedge clk);
    if (shoot) begin
      if (bullet_write_dxy && spaceship_write_dxy) pulses++;
      chk("shoot_enable", {bullet_enable_update, spaceship_enable_update}, 2'b11);
    end
    {collision, collision_bullet, spaceship_within_screen, bullet_within_screen} = 4'b0011;
    target_within_screen = '1;
    chk("end_round", state_dbg, 4);
    chk("round_score", score, exp_score);
    chk("round_lives", n_lives, exp_lives);
    chk("round_heart", heart_visible, hearts(exp_lives));
    @(negedge clk);
    if (shoot) begin
      if (bullet_write_dxy && spaceship_write_dxy) pulses++;
      chk("dxy_pulses", pulses, 1);
    end
    chk("after_round", state_dbg, (exp_score == WS || exp_lives == 0) ? 5 : 1);
    if (state_dbg == 3'd5) end_game();
  endtask
  initial begin
    int directed[7] = '{2, 2, 2, 0, 0, 0, 3};
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    foreach (directed[i]) play_round(directed[i]);
    repeat (40) play_round($urandom_range(0, 5));
    start_round();
    launch_key = 1'b1;
    @(negedge clk);
    launch_key = 1'b0;
    chk("pre_rst_shoot", state_dbg, 3);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_score = 0;
    exp_lives = ML;
    start_round();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
